// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(n), but never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit_add.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
// Used by serial_adder (optional subtract: SERIAL_ADDER_SUB_EN).
module digit_add #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder reusing one DIGIT-bit slice for WIDTH/DIGIT cycles.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b as a + ~b + 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
    $error("serial_adder: WIDTH must be >= 1 and an exact multiple of DIGIT >= 1");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic [DIGIT-1:0]       digit_sum;
  logic                   digit_carry;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       b_load;
  logic                   cin_load;

  // Subtraction is folded into the operand load so the datapath stays add-only.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub ? 1'b1 : cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  digit_add #(.DIGIT(DIGIT)) u_digit (
    .a    (a_reg[DIGIT-1:0]),
    .b    (b_reg[DIGIT-1:0]),
    .cin  (carry_reg),
    .s    (digit_sum),
    .cout (digit_carry)
  );

  // New digit enters at the MSB end; after N shifts digit 0 sits at bit 0.
  assign sum_cat = {digit_sum, sum_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b_load;
            carry_reg <= cin_load;
            cnt_reg   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          carry_reg <= digit_carry;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            cout_reg <= digit_carry;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder in three shapes (8/1, 1/1, 8/4).
// Subtract cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  // Shared stimulus; 'sel' routes in_valid to one instance at a time.
  int         sel = 0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b0;

  logic       ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, bz0, bz1, bz2;
  logic [7:0] s0, s2;
  logic [0:0] s1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir0),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov0), .out_ready(out_ready && sel == 0), .sum(s0), .cout(co0), .busy(bz0));

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir1),
    .a(a[0:0]), .b(b[0:0]), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov1), .out_ready(out_ready && sel == 1), .sum(s1), .cout(co1), .busy(bz1));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir2),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov2), .out_ready(out_ready && sel == 2), .sum(s2), .cout(co2), .busy(bz2));

  logic       o_ir, o_ov, o_co, o_bz;
  logic [7:0] o_sum;

  always_comb begin
    o_ir = ir0; o_ov = ov0; o_co = co0; o_bz = bz0; o_sum = s0;
    if (sel == 1) begin
      o_ir = ir1; o_ov = ov1; o_co = co1; o_bz = bz1; o_sum = {7'b0, s1};
    end else if (sel == 2) begin
      o_ir = ir2; o_ov = ov2; o_co = co2; o_bz = bz2; o_sum = s2;
    end
  end

  function automatic int width_of(input int s);
    return (s == 1) ? 1 : 8;
  endfunction

  function automatic int digits_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 1 : 2;
  endfunction

  // Reference: {cout,sum} = a + b + cin (or a - b as a + ~b + 1) modulo 2^(W+1).
  function automatic longint model(input int w, input longint av, input longint bv,
                                   input longint cv, input bit sv);
    longint mw, r;
    mw = (64'd1 << w) - 1;
    if (SUB_EN && sv) r = (av & mw) + ((~bv) & mw) + 1;
    else              r = (av & mw) + (bv & mw) + cv;
    return r & ((64'd1 << (w + 1)) - 1);
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic txn(input int s, input logic [7:0] av, input logic [7:0] bv,
                     input logic cv, input logic sv, input int hold);
    int     w, lat;
    longint exp;
    logic [7:0] held_sum;
    logic       held_co;
    w = width_of(s);
    @(posedge clk); #1;
    sel = s;
    #1;
    check("in_ready_idle", o_ir, 1);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
    check("busy_run", o_bz, 1);
    lat = 0;
    while (!o_ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, digits_of(s));
    exp = model(w, av, bv, cv, sv);
    check("sum", o_sum, exp & ((64'd1 << w) - 1));
    check("cout", o_co, exp >> w);
    check("in_ready_done", o_ir, 0);
    held_sum = o_sum; held_co = o_co;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", o_ov, 1);
      check("hold_stable", {o_co, o_sum}, {held_co, held_sum});
    end
    in_valid = 1'b0;
    $display("txn inst=%0d a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d hold=%0d",
             s, av, bv, cv, sv, held_sum, held_co, lat, hold);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", o_ov, 0);
    check("release_ready", o_ir, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_ready", o_ir, 0);
      check("rst_valid", o_ov, 0);
      check("rst_sum", o_sum, 0);
      check("rst_busy", {o_bz, o_co}, 0);
    end
    @(negedge clk); rst_n = 1'b1;

    txn(0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    txn(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
    txn(0, 8'h7F, 8'h01, 1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++)
      txn(1, 8'(i >> 2), 8'((i >> 1) & 1), 1'((i & 1)), 1'b0, 0);
    txn(2, 8'hA5, 8'h5A, 1'b1, 1'b0, 5);

    // Abort an operation after three digits with an asynchronous reset.
    @(posedge clk); #1;
    sel = 0; a = 8'hC3; b = 8'h3C; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrun_valid", o_ov, 0);
    check("midrun_sum", o_sum, 0);
    check("midrun_busy", o_bz, 0);
    check("midrun_ready", o_ir, 0);
    $display("txn inst=0 reset asserted mid-run");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", o_ir, 1);
    txn(0, 8'h10, 8'h20, 1'b0, 1'b0, 0);

    if (SUB_EN) begin
      txn(0, 8'h05, 8'h07, 1'b1, 1'b1, 0);
      txn(0, 8'h07, 8'h05, 1'b0, 1'b1, 0);
      txn(2, 8'h05, 8'h07, 1'b0, 1'b1, 1);
    end

    for (int i = 0; i < 30; i++)
      txn($urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'($urandom),
          SUB_EN ? 1'($urandom) : 1'b0, $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
